// File: rtl/addsub_pkg.sv
// Shared types and helpers for the chunked add/subtract responder.
package addsub_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed overflow: operands (after the subtract inversion) agree in sign
  // but the result sign differs from them.
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit adder slice with carry in/out.
module addsub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/addsub_seq_resp.sv
// Handshaked add/subtract responder: one CHUNK-wide slice per CALC cycle,
// carry rippled through a register between slices.
module addsub_seq_resp
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int MSB    = WIDTH - 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("addsub_seq_resp: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;        // b already inverted for subtract
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_carry_q, out_carry_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_zero_q, out_zero_d;

  logic [CHUNK-1:0]  c_a, c_b, c_s;
  logic              c_cout;
  logic              last_chunk;

  assign c_a        = a_q[idx_q*CHUNK +: CHUNK];
  assign c_b        = b_q[idx_q*CHUNK +: CHUNK];
  assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

  addsub_chunk #(.W(CHUNK)) u_chunk (
    .a    (c_a),
    .b    (c_b),
    .cin  (carry_q),
    .s    (c_s),
    .cout (c_cout)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_carry_d = out_carry_q;
    out_ovf_d   = out_ovf_q;
    out_zero_d  = out_zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = in_a;
          b_d        = in_sub ? ~in_b : in_b;
          carry_d    = in_sub;     // +1 completes the two's-complement negate
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        sum_d[idx_q*CHUNK +: CHUNK] = c_s;
        carry_d = c_cout;
        if (last_chunk) begin
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_carry_d = c_cout;
          out_ovf_d   = calc_ovf(a_q[MSB], b_q[MSB], sum_d[MSB]);
          out_zero_d  = ~|sum_d;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State registers; async reset drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_carry_q <= out_carry_d;
      out_ovf_q   <= out_ovf_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_carry = out_carry_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;

endmodule
